// File: rtl/switch_allocator_rr_if.sv
// rtl/switch_allocator_rr_if.sv - request/credit/crossbar bundle for the round-robin switch allocator
// Purpose : groups the input-buffer requests, downstream credits and the allocator's crossbar
//           select/enable and dequeue grant lines into one interface.
// Signals : valid, req_outport, req_vc, tail   per buffer, driven by the input buffers
//           credit_avail                         per (outport, VC), downstream credit state
//           reg_bank_claim                       freeze, blocks new locks
//           select, enable                       per (outport, VC), to the crossbar
//           grant                                per buffer, dequeue strobe
//           flit_count                           per outport, only with SA_PERF_COUNTERS_EN
// Modports: master = requester/credit side, slave = allocator.
// Config  : SA_PERF_COUNTERS_EN adds flit_count.
interface switch_allocator_rr_if #(
   parameter int NUM_BUFFERS  = 5,
   parameter int NUM_OUTPORTS = 5,
   parameter int NUM_VCS      = 2
);
   localparam int SELECT_SIZE = $clog2(NUM_BUFFERS) + int'(NUM_BUFFERS == 1);
   localparam int OUT_W       = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1;
   localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   logic [NUM_BUFFERS-1:0]                                valid;
   logic [NUM_BUFFERS-1:0][OUT_W-1:0]                     req_outport;
   logic [NUM_BUFFERS-1:0][VC_W-1:0]                      req_vc;
   logic [NUM_BUFFERS-1:0]                                tail;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                  credit_avail;
   logic                                                  reg_bank_claim;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SELECT_SIZE-1:0] select;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                  enable;
   logic [NUM_BUFFERS-1:0]                                grant;
`ifdef SA_PERF_COUNTERS_EN
   logic [NUM_OUTPORTS-1:0][15:0]                         flit_count;

   modport master (output valid, req_outport, req_vc, tail, credit_avail, reg_bank_claim,
                   input  select, enable, grant, flit_count);
   modport slave  (input  valid, req_outport, req_vc, tail, credit_avail, reg_bank_claim,
                   output select, enable, grant, flit_count);
`else
   modport master (output valid, req_outport, req_vc, tail, credit_avail, reg_bank_claim,
                   input  select, enable, grant);
   modport slave  (input  valid, req_outport, req_vc, tail, credit_avail, reg_bank_claim,
                   output select, enable, grant);
`endif
endinterface

// File: rtl/switch_allocator_rr.sv
// rtl/switch_allocator_rr.sv - packet-level round-robin switch allocator for the chiplet switch
// Purpose : each (outport, VC) pair is locked by one input buffer from head to tail flit.
//           Idle pairs pick a new owner round-robin among requesting buffers; each outport
//           then picks one ready VC per cycle round-robin and drives the crossbar.
// Ports   : clk  clock
//           rst  asynchronous active-high reset
//           sa   switch_allocator_rr_if.slave (requests, credits, select/enable/grant)
// Config  : SA_PERF_COUNTERS_EN adds saturating per-outport transfer counters (sa.flit_count).
module switch_allocator_rr #(
   parameter int NUM_BUFFERS  = 5,
   parameter int NUM_OUTPORTS = 5,
   parameter int NUM_VCS      = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   switch_allocator_rr_if.slave sa
);
   localparam int SELECT_SIZE = $clog2(NUM_BUFFERS) + int'(NUM_BUFFERS == 1);
   localparam int OUT_W       = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1;
   localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   typedef enum logic {PAIR_IDLE, PAIR_LOCKED} pair_state_e;

   pair_state_e                                           state_q [NUM_OUTPORTS][NUM_VCS];
   pair_state_e                                           state_d [NUM_OUTPORTS][NUM_VCS];
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SELECT_SIZE-1:0] owner_q, owner_d;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SELECT_SIZE-1:0] pair_ptr_q, pair_ptr_d;
   logic [NUM_OUTPORTS-1:0][VC_W-1:0]                     vc_ptr_q, vc_ptr_d;
   logic [NUM_BUFFERS-1:0]                                busy;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                  ready;
   logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                  enable;
   logic [NUM_BUFFERS-1:0]                                grant;

   // A buffer owning a lock is busy and may not compete for another pair.
   always_comb begin
      busy  = '0;
      ready = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (state_q[o][v] == PAIR_LOCKED) begin
               busy[owner_q[o][v]] = 1'b1;
               ready[o][v]         = sa.valid[owner_q[o][v]] & sa.credit_avail[o][v];
            end
         end
      end
   end

   // Link arbitration. The two sweeps give indices at/after the pointer priority over
   // the wrapped-around ones, which is round-robin without a modulo on a variable index.
   always_comb begin
      logic found;
      found    = 1'b0;
      enable   = '0;
      vc_ptr_d = vc_ptr_q;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         found = 1'b0;
         for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
               if (!found && ready[o][v] && (pass == 1 || VC_W'(v) >= vc_ptr_q[o])) begin
                  found        = 1'b1;
                  enable[o][v] = 1'b1;
                  vc_ptr_d[o]  = (v == NUM_VCS - 1) ? '0 : VC_W'(v + 1);
               end
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (enable[o][v]) grant[owner_q[o][v]] = 1'b1;
         end
      end
   end

   // Pair FSM: release on an enabled tail flit, lock an idle pair to the round-robin winner.
   // A releasing pair is still LOCKED this cycle, so it re-locks no earlier than one edge later.
   always_comb begin
      logic found;
      found      = 1'b0;
      state_d    = state_q;
      owner_d    = owner_q;
      pair_ptr_d = pair_ptr_q;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            found = 1'b0;
            if (state_q[o][v] == PAIR_LOCKED) begin
               if (enable[o][v] && sa.tail[owner_q[o][v]]) begin
                  state_d[o][v] = PAIR_IDLE;
                  owner_d[o][v] = '0;
               end
            end else if (!sa.reg_bank_claim) begin
               for (int pass = 0; pass < 2; pass++) begin
                  for (int b = 0; b < NUM_BUFFERS; b++) begin
                     if (!found && sa.valid[b] && !busy[b] &&
                         sa.req_outport[b] == OUT_W'(o) && sa.req_vc[b] == VC_W'(v) &&
                         (pass == 1 || SELECT_SIZE'(b) >= pair_ptr_q[o][v])) begin
                        found            = 1'b1;
                        state_d[o][v]    = PAIR_LOCKED;
                        owner_d[o][v]    = SELECT_SIZE'(b);
                        pair_ptr_d[o][v] = (b == NUM_BUFFERS - 1) ? '0 : SELECT_SIZE'(b + 1);
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
               state_q[o][v] <= PAIR_IDLE;
            end
         end
         owner_q    <= '0;
         pair_ptr_q <= '0;
         vc_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         pair_ptr_q <= pair_ptr_d;
         vc_ptr_q   <= vc_ptr_d;
      end
   end

   assign sa.select = owner_q;
   assign sa.enable = enable;
   assign sa.grant  = grant;

`ifdef SA_PERF_COUNTERS_EN
   logic [NUM_OUTPORTS-1:0][15:0] flit_count_q, flit_count_d;

   always_comb begin
      flit_count_d = flit_count_q;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         if ((|enable[o]) && flit_count_q[o] != 16'hFFFF) flit_count_d[o] = flit_count_q[o] + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) flit_count_q <= '0;
      else     flit_count_q <= flit_count_d;
   end

   assign sa.flit_count = flit_count_q;
`endif
endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb/tb_switch_allocator_rr.sv - self-checking bench for switch_allocator_rr against a reference model
module tb_switch_allocator_rr;
   localparam int NB = 5;
   localparam int NO = 5;
   localparam int NV = 2;
   localparam int SS = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   switch_allocator_rr_if #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV)) sa_if ();
   switch_allocator_rr #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV)) dut (
      .clk (clk),
      .rst (rst),
      .sa  (sa_if)
   );

   int checks = 0;
   int errors = 0;

   // Buffer stimulus: remaining flits of the current packet, its route, and what happens after
   // the tail (0 = go empty, 1 = same packet again, 2 = new random packet).
   int b_len [NB];
   int b_plen[NB];
   int b_out [NB];
   int b_vc  [NB];
   int b_mode[NB];
   bit cr[NO][NV];
   bit claim;
   bit rnd_on;

   // Reference model: pair ownership (-1 = idle) and round-robin pointers.
   int m_own [NO][NV];
   int m_ptr [NO][NV];
   int m_vptr[NO];
   int m_cnt [NO];

   logic [NO-1:0][NV-1:0]         obs_en;
   logic [NO-1:0][NV-1:0][SS-1:0] obs_sel;
   logic [NB-1:0]                 obs_gnt;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_all();
      for (int b = 0; b < NB; b++) begin
         b_len[b] = 0; b_plen[b] = 0; b_out[b] = 0; b_vc[b] = 0; b_mode[b] = 0;
      end
      for (int o = 0; o < NO; o++) begin
         for (int v = 0; v < NV; v++) begin
            cr[o][v] = 1'b0; m_own[o][v] = -1; m_ptr[o][v] = 0;
         end
         m_vptr[o] = 0; m_cnt[o] = 0;
      end
      claim = 1'b0; rnd_on = 1'b0;
      sa_if.valid = '0; sa_if.req_outport = '0; sa_if.req_vc = '0; sa_if.tail = '0;
      sa_if.credit_avail = '0; sa_if.reg_bank_claim = 1'b0;
   endtask

   task automatic set_packet(input int b, input int o, input int v, input int len, input int mode);
      b_out[b] = o; b_vc[b] = v; b_len[b] = len; b_plen[b] = len; b_mode[b] = mode;
   endtask

   task automatic random_packet(input int b);
      set_packet(b, $urandom_range(0, NO - 1), $urandom_range(0, NV - 1), $urandom_range(1, 4), 2);
   endtask

   task automatic set_credit(input bit val);
      for (int o = 0; o < NO; o++) for (int v = 0; v < NV; v++) cr[o][v] = val;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, compare with the model shortly after,
   // then advance the model and the buffers on the rising edge.
   task automatic run_cycle();
      logic [NO-1:0][NV-1:0]         xe;
      logic [NO-1:0][NV-1:0][SS-1:0] xs;
      logic [NO-1:0][NV-1:0][SS-1:0] os;
      logic [NB-1:0]                 xg;
      bit                            owns[NB];
      int                            w, vv, bb;
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
         sa_if.valid[b]       = (b_len[b] > 0) && (!rnd_on || $urandom_range(0, 99) < 85);
         sa_if.req_outport[b] = 3'(b_out[b]);
         sa_if.req_vc[b]      = 1'(b_vc[b]);
         sa_if.tail[b]        = (b_len[b] == 1);
      end
      for (int o = 0; o < NO; o++)
         for (int v = 0; v < NV; v++)
            sa_if.credit_avail[o][v] = rnd_on ? ($urandom_range(0, 99) < 75) : cr[o][v];
      sa_if.reg_bank_claim = rnd_on ? ($urandom_range(0, 99) < 10) : claim;
      #1;
      xe = '0; xs = '0; xg = '0; os = '0;
      for (int o = 0; o < NO; o++) begin
         w = -1;
         for (int k = 0; k < NV; k++) begin
            vv = (m_vptr[o] + k) % NV;
            if (w < 0 && m_own[o][vv] >= 0 && sa_if.valid[m_own[o][vv]] && sa_if.credit_avail[o][vv]) w = vv;
         end
         if (w >= 0) begin
            xe[o][w] = 1'b1;
            xg[m_own[o][w]] = 1'b1;
         end
         for (int v = 0; v < NV; v++) begin
            if (m_own[o][v] >= 0) begin
               xs[o][v] = SS'(m_own[o][v]);
               os[o][v] = sa_if.select[o][v];
            end
         end
      end
      obs_en = sa_if.enable; obs_sel = sa_if.select; obs_gnt = sa_if.grant;
      check_eq("enable", 64'(obs_en), 64'(xe));
      check_eq("grant", 64'(obs_gnt), 64'(xg));
      check_eq("select_locked", 64'(os), 64'(xs));
`ifdef SA_PERF_COUNTERS_EN
      for (int o = 0; o < NO; o++) check_eq("flit_count", 64'(sa_if.flit_count[o]), 64'(m_cnt[o]));
`endif
      @(posedge clk);
      for (int b = 0; b < NB; b++) owns[b] = 1'b0;
      for (int o = 0; o < NO; o++) for (int v = 0; v < NV; v++) if (m_own[o][v] >= 0) owns[m_own[o][v]] = 1'b1;
      for (int o = 0; o < NO; o++) begin
         for (int v = 0; v < NV; v++) begin
            if (m_own[o][v] >= 0) begin
               if (xe[o][v] && sa_if.tail[m_own[o][v]]) m_own[o][v] = -1;
            end else if (!sa_if.reg_bank_claim) begin
               w = -1;
               for (int k = 0; k < NB; k++) begin
                  bb = (m_ptr[o][v] + k) % NB;
                  if (w < 0 && sa_if.valid[bb] && !owns[bb] && int'(sa_if.req_outport[bb]) == o &&
                      int'(sa_if.req_vc[bb]) == v) w = bb;
               end
               if (w >= 0) begin
                  m_own[o][v] = w;
                  m_ptr[o][v] = (w + 1) % NB;
               end
            end
            if (xe[o][v]) begin
               m_vptr[o] = (v + 1) % NV;
               if (m_cnt[o] < 65535) m_cnt[o]++;
            end
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (xg[b]) begin
            b_len[b]--;
            if (b_len[b] == 0) begin
               if (b_mode[b] == 1) b_len[b] = b_plen[b];
               else if (b_mode[b] == 2) random_packet(b);
            end
         end
      end
   endtask

   initial begin
      int en_cnt, g_cnt;
      int owners[$];
      logic [1:0] exp_alt;
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("reset_enable", 64'(sa_if.enable), 64'd0);
      check_eq("reset_grant", 64'(sa_if.grant), 64'd0);
      check_eq("reset_select", 64'(sa_if.select), 64'd0);
      rst = 1'b0;

      // Reset while a packet is mid-transfer: locks vanish without waiting for a clock.
      set_packet(2, 1, 0, 10, 0);
      set_credit(1'b1);
      repeat (3) run_cycle();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("midreset_enable", 64'(sa_if.enable), 64'd0);
      check_eq("midreset_grant", 64'(sa_if.grant), 64'd0);
      check_eq("midreset_select", 64'(sa_if.select), 64'd0);
      clear_all();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) run_cycle();

      // Single requester, 3-flit packet.
      do_reset();
      set_packet(2, 1, 0, 3, 0);
      set_credit(1'b1);
      en_cnt = 0; g_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         en_cnt += int'(obs_en[1][0]);
         g_cnt  += int'(obs_gnt[2]);
         if (i == 1) check_eq("t2_select", 64'(obs_sel[1][0]), 64'd2);
      end
      check_eq("t2_enable_cycles", 64'(en_cnt), 64'd3);
      check_eq("t2_grant_cycles", 64'(g_cnt), 64'd3);

      // Contention: three buffers, repeated single-flit packets to out0/vc1.
      do_reset();
      set_credit(1'b1);
      set_packet(0, 0, 1, 1, 1);
      set_packet(3, 0, 1, 1, 1);
      set_packet(4, 0, 1, 1, 1);
      owners.delete();
      for (int i = 0; i < 12; i++) begin
         run_cycle();
         if (obs_en[0][1]) owners.push_back(int'(obs_sel[0][1]));
      end
      check_eq("t3_transfers", 64'(owners.size() >= 4), 64'd1);
      if (owners.size() >= 4) begin
         check_eq("t3_owner0", 64'(owners[0]), 64'd0);
         check_eq("t3_owner1", 64'(owners[1]), 64'd3);
         check_eq("t3_owner2", 64'(owners[2]), 64'd4);
         check_eq("t3_owner3", 64'(owners[3]), 64'd0);
      end

      // Two VCs sharing outport 2 alternate every cycle.
      do_reset();
      set_credit(1'b1);
      set_packet(1, 2, 0, 8, 0);
      set_packet(3, 2, 1, 8, 0);
      run_cycle();
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         exp_alt = (i % 2 == 0) ? 2'b01 : 2'b10;
         check_eq("t4_alternate", 64'(obs_en[2]), 64'(exp_alt));
      end

      // Credit loss holds the lock; freeze blocks new locks only.
      do_reset();
      set_credit(1'b1);
      set_packet(0, 0, 0, 5, 0);
      repeat (3) run_cycle();
      cr[0][0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check_eq("t5_nocredit", 64'(obs_en[0]), 64'd0);
      end
      cr[0][0] = 1'b1;
      en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         en_cnt += int'(obs_en[0][0]);
      end
      check_eq("t5_resume", 64'(en_cnt), 64'd3);
      claim = 1'b1;
      set_packet(4, 3, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check_eq("t5_frozen", 64'(obs_en[3]), 64'd0);
      end
      claim = 1'b0;
      en_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         en_cnt += int'(obs_en[3][1]);
      end
      check_eq("t5_unfrozen", 64'(en_cnt), 64'd1);

      // Randomized traffic, credits and freeze.
      do_reset();
      for (int b = 0; b < NB; b++) random_packet(b);
      rnd_on = 1'b1;
      repeat (4000) run_cycle();

`ifdef SA_PERF_COUNTERS_EN
      do_reset();
      set_credit(1'b1);
      set_packet(0, 0, 0, 70010, 0);
      repeat (70002) run_cycle();
      check_eq("flit_count_saturated", 64'(sa_if.flit_count[0]), 64'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
